// File: rtl/icache_controller.sv
// icache_controller: direct-mapped 8 x 128-bit instruction cache with a blocking single-block refill.
// Defining ICACHE_STATS_EN adds saturating hit/miss counters on o_hit_count/o_miss_count.
module icache_controller (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_read,
  input  logic [9:0]   i_address,
  output logic [31:0]  o_instruction,
  output logic         o_busywait,
  output logic         o_mem_read,
  output logic [5:0]   o_mem_address,
  input  logic [127:0] i_mem_readdata,
  input  logic         i_mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  o_hit_count,
  output logic [15:0]  o_miss_count
`endif
);
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  state_t       r_state;
  logic [127:0] r_data [8];
  logic [2:0]   r_tag [8];
  logic [7:0]   r_valid;
  logic [2:0]   r_miss_index, r_miss_tag;
  logic         r_first;
  logic [31:0]  r_instruction;
  logic [2:0]   w_tag, w_index;
  logic [1:0]   w_word;
  logic         w_hit, w_miss, w_unused;
  logic [31:0]  w_word_data;
  assign w_tag = i_address[9:7];
  assign w_index = i_address[6:4];
  assign w_word = i_address[3:2];
  assign w_unused = &{1'b0, i_address[1:0]};
  assign w_hit = i_read && r_state == IDLE && r_valid[w_index] && r_tag[w_index] == w_tag;
  assign w_miss = i_read && r_state == IDLE && !w_hit;
  assign w_word_data = r_data[w_index][{w_word, 5'd0} +: 32];
  assign o_instruction = w_hit ? w_word_data : r_instruction;
  assign o_busywait = !i_reset && (w_miss || r_state != IDLE);
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_first <= 1'b0;
      r_miss_index <= '0;
      r_miss_tag <= '0;
      r_instruction <= '0;
      o_mem_read <= 1'b0;
      o_mem_address <= '0;
    end else begin
      r_instruction <= o_instruction;
      case (r_state)
        IDLE: if (w_miss) begin
          r_state <= MEM_READ;
          r_miss_index <= w_index;
          r_miss_tag <= w_tag;
          r_first <= 1'b1;
          o_mem_read <= 1'b1;
          o_mem_address <= {w_tag, w_index};
        end
        // memory only raises busywait after seeing mem_read, so the first cycle's low busywait is stale
        MEM_READ: begin
          r_first <= 1'b0;
          if (!r_first && !i_mem_busywait) begin
            r_state <= UPDATE;
            o_mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          r_valid[r_miss_index] <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  always_ff @(posedge i_clock)
    if (!i_reset && r_state == UPDATE) begin
      r_data[r_miss_index] <= i_mem_readdata;
      r_tag[r_miss_index] <= r_miss_tag;
    end
`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_count, r_miss_count;
  assign o_hit_count = r_hit_count;
  assign o_miss_count = r_miss_count;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_hit_count <= '0;
      r_miss_count <= '0;
    end else begin
      r_hit_count <= (w_hit && r_hit_count != 16'hFFFF) ? r_hit_count + 16'd1 : r_hit_count;
      r_miss_count <= (w_miss && r_miss_count != 16'hFFFF) ? r_miss_count + 16'd1 : r_miss_count;
    end
`endif
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed scenarios against a fixed-latency block memory model.
module tb_icache_controller;
  logic         clk = 1'b0, rst = 1'b0, read = 1'b0, mem_busywait = 1'b0;
  logic [9:0]   address = '0;
  logic [31:0]  instruction;
  logic         busywait, mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  int           vectors = 0, errors = 0, m_reads = 0, m_cnt = 0;
  logic         m_prev = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  icache_controller dut (
    .i_clock(clk), .i_reset(rst), .i_read(read), .i_address(address),
    .o_instruction(instruction), .o_busywait(busywait), .o_mem_read(mem_read),
    .o_mem_address(mem_address), .i_mem_readdata(mem_readdata), .i_mem_busywait(mem_busywait)
`ifdef ICACHE_STATS_EN
    , .o_hit_count(hit_count), .o_miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // word n of block a is 32'hA500_0000 | a<<8 | n
  function automatic logic [127:0] blk(input logic [5:0] a);
    for (int n = 0; n < 4; n++) blk[32*n +: 32] = 32'hA500_0000 | (32'(a) << 8) | 32'(n);
  endfunction

  // memory: busy for 2 cycles after seeing mem_read, then data valid with busywait low
  always @(posedge clk) begin
    m_prev <= mem_read;
    if (mem_read && !m_prev) m_reads <= m_reads + 1;
    if (!mem_read) begin
      m_cnt <= 0;
      mem_busywait <= 1'b0;
      mem_readdata <= '0;
    end else if (m_cnt < 2) begin
      m_cnt <= m_cnt + 1;
      mem_busywait <= 1'b1;
    end else begin
      mem_busywait <= 1'b0;
      mem_readdata <= blk(mem_address);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    read = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (busywait && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (busywait) begin errors++; $display("FAIL %s timeout: busywait=%b want 0", nm, busywait); end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; read = 1'b1; address = 10'h000;
    #1;
    vectors += 4;
    if (busywait !== 1'b0) begin errors++; $display("FAIL rst_busywait got %b want 0", busywait); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %b want 0", mem_read); end
    if (mem_address !== 6'h00) begin errors++; $display("FAIL rst_mem_address got %h want 00", mem_address); end
    if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction got %h want 0", instruction); end
    step();
    read = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    int n;
    read = 1'b1; address = 10'h000;
    #1;
    vectors++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL cold_busywait got %b want 1", busywait); end
    step();
    vectors += 2;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL cold_mem_read got %b want 1", mem_read); end
    if (mem_address !== 6'h00) begin errors++; $display("FAIL cold_mem_address got %h want 00", mem_address); end
    wait_ready("cold_wait", n);
    vectors += 2;
    if (n != 5) begin errors++; $display("FAIL cold_penalty got %0d want 5", n); end
    if (instruction !== 32'hA500_0000) begin errors++; $display("FAIL cold_instr got %h want a5000000", instruction); end
  endtask

  task automatic test_hits();
    logic [9:0]  addrs [3] = '{10'h004, 10'h008, 10'h00C};
    logic [31:0] exp   [3] = '{32'hA500_0001, 32'hA500_0002, 32'hA500_0003};
    int r0 = m_reads;
    for (int i = 0; i < 3; i++) begin
      address = addrs[i];
      #1;
      vectors += 2;
      if (busywait !== 1'b0) begin errors++; $display("FAIL hit%0d_busywait got %b want 0", i, busywait); end
      if (instruction !== exp[i]) begin errors++; $display("FAIL hit%0d_instr got %h want %h", i, instruction, exp[i]); end
      step();
    end
    read = 1'b0; address = 10'h004;
    step();
    vectors += 3;
    if (m_reads != r0) begin errors++; $display("FAIL hit_no_mem_read got %0d want %0d", m_reads, r0); end
    if (busywait !== 1'b0) begin errors++; $display("FAIL idle_busywait got %b want 0", busywait); end
    if (instruction !== 32'hA500_0003) begin errors++; $display("FAIL idle_hold got %h want a5000003", instruction); end
  endtask

  task automatic test_conflict();
    int n;
    read = 1'b1; address = 10'h080;
    #1;
    vectors++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL conf_miss got %b want 1", busywait); end
    step();
    vectors++;
    if (mem_address !== 6'h08) begin errors++; $display("FAIL conf_mem_address got %h want 08", mem_address); end
    wait_ready("conf_wait", n);
    vectors++;
    if (instruction !== 32'hA500_0800) begin errors++; $display("FAIL conf_instr got %h want a5000800", instruction); end
    address = 10'h000;
    #1;
    vectors++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL conf_evict got %b want 1", busywait); end
    step();
    vectors++;
    if (mem_address !== 6'h00) begin errors++; $display("FAIL conf_mem_address2 got %h want 00", mem_address); end
    wait_ready("conf_wait2", n);
    vectors++;
    if (instruction !== 32'hA500_0000) begin errors++; $display("FAIL conf_instr2 got %h want a5000000", instruction); end
  endtask

  task automatic test_reset_mid();
    int n;
    read = 1'b1; address = 10'h040;
    step();
    vectors++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_mem_read got %b want 1", mem_read); end
    rst = 1'b1;
    #1;
    vectors += 2;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rmid_mem_read_drop got %b want 0", mem_read); end
    if (busywait !== 1'b0) begin errors++; $display("FAIL rmid_busywait got %b want 0", busywait); end
    step();
    rst = 1'b0; address = 10'h000;
    #1;
    vectors++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL rmid_valid_cleared got %b want 1", busywait); end
    step();
    wait_ready("rmid_wait", n);
  endtask

  task automatic test_addr_change();
    int n;
    read = 1'b1; address = 10'h010;
    step();
    vectors++;
    if (mem_address !== 6'h01) begin errors++; $display("FAIL chg_mem_address got %h want 01", mem_address); end
    address = 10'h020;
    step();
    vectors++;
    if (mem_address !== 6'h01) begin errors++; $display("FAIL chg_latched got %h want 01", mem_address); end
    n = 0;
    while (!(mem_read && mem_address == 6'h02) && n < 100) begin step(); n++; end
    vectors++;
    if (!(mem_read === 1'b1 && mem_address === 6'h02)) begin errors++; $display("FAIL chg_second_miss got %b/%h want 1/02", mem_read, mem_address); end
    wait_ready("chg_wait", n);
    vectors++;
    if (instruction !== 32'hA500_0200) begin errors++; $display("FAIL chg_instr got %h want a5000200", instruction); end
    address = 10'h010;
    #1;
    vectors += 2;
    if (busywait !== 1'b0) begin errors++; $display("FAIL chg_line1_hit got %b want 0", busywait); end
    if (instruction !== 32'hA500_0100) begin errors++; $display("FAIL chg_line1_instr got %h want a5000100", instruction); end
    step();
  endtask

  task automatic test_read_drop();
    int n;
    read = 1'b1; address = 10'h030;
    step();
    read = 1'b0;
    wait_ready("drop_wait", n);
    read = 1'b1; address = 10'h034;
    #1;
    vectors += 2;
    if (busywait !== 1'b0) begin errors++; $display("FAIL drop_hit got %b want 0", busywait); end
    if (instruction !== 32'hA500_0301) begin errors++; $display("FAIL drop_instr got %h want a5000301", instruction); end
    step();
    read = 1'b0;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    vectors += 2;
    if (hit_count !== 16'd0) begin errors++; $display("FAIL stat_hit_rst got %0d want 0", hit_count); end
    if (miss_count !== 16'd0) begin errors++; $display("FAIL stat_miss_rst got %0d want 0", miss_count); end
    read = 1'b1; address = 10'h050;
    step();
    wait_ready("stat_wait", n);
    read = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      read = 1'b1; address = 10'h050 + 10'(4 * i);
      step();
    end
    read = 1'b0;
    step();
    vectors += 2;
    if (hit_count !== 16'd3) begin errors++; $display("FAIL stat_hits got %0d want 3", hit_count); end
    if (miss_count !== 16'd1) begin errors++; $display("FAIL stat_misses got %0d want 1", miss_count); end
  endtask
`endif

  initial begin
    step();
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_reset_mid();
    test_addr_change();
    test_read_drop();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/icache_controller.md
ICACHE_CONTROLLER -- requirements
Module: icache_controller

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 read  input  1  CPU instruction-fetch request.
REQ-005 address  input  10  CPU byte address: tag[9:7], index[6:4], word[3:2]; [1:0] ignored.
REQ-006 instruction  output  32  fetched instruction word.
REQ-007 busywait  output  1  CPU stall; high while the request is not yet served.
REQ-008 mem_read  output  1  block-read request to instruction memory.
REQ-009 mem_address  output  6  block address to instruction memory.
REQ-010 mem_readdata  input  128  16-byte block from memory; byte 0 in bits [7:0].
REQ-011 mem_busywait  input  1  memory busy; falls when mem_readdata is valid.

Function
REQ-012 Organisation: direct-mapped, 8 lines x 128 bits, with a 3-bit tag and 1 valid bit per line.
REQ-013 Hit: read=1, state IDLE, valid[index]=1, tag[index]=address[9:7].
REQ-014 On a hit, instruction = line[index] word address[3:2] (word n = bits [32n+31:32n]), combinationally; busywait=0; zero-cycle latency.
REQ-015 With read=0, busywait=0 and instruction holds its last value; no memory traffic.
REQ-016 On a miss, busywait=1 combinationally in the same cycle.
REQ-017 On a miss, at the next posedge the block latches miss_index=address[6:4] and miss_tag=address[9:7], then enters MEM_READ.
REQ-018 States: IDLE, MEM_READ, UPDATE. No other states are reachable.
REQ-019 IDLE -> MEM_READ on a miss; otherwise IDLE holds.
REQ-020 In MEM_READ: mem_read=1; mem_address={miss_tag,miss_index}; busywait=1.
REQ-021 MEM_READ -> UPDATE at the first posedge where mem_busywait=0, excluding the first MEM_READ cycle (memory raises busywait in response to mem_read).
REQ-022 In UPDATE: mem_read=0; busywait=1.
REQ-023 At the UPDATE posedge: line[miss_index]=mem_readdata, tag[miss_index]=miss_tag, valid[miss_index]=1; then enter IDLE.
REQ-024 In IDLE after a refill, the current address is re-evaluated: a hit releases busywait.
REQ-025 An address changed during a refill completes the latched fill; the new address is then treated as a fresh access (hit or miss).
REQ-026 read deasserted mid-refill: the refill still completes and the line is written.
REQ-027 Minimum miss penalty: 1 (IDLE) + 1 (MEM_READ issue) + the memory busy time + 1 (UPDATE) cycles.
REQ-028 mem_read is a registered, state-decoded output and never glitches outside MEM_READ.

Reset
REQ-029 Reset asserted: immediately state=IDLE, all valid bits=0, mem_read=0, mem_address=0, instruction=0.
REQ-030 While reset is asserted, busywait=0.
REQ-031 Reset mid-refill: the refill is abandoned, no line is written, and mem_read=0 within the same instant.
REQ-032 Data and tag arrays are not cleared by reset; valid bits alone gate hits.

Configuration
REQ-033 Macro ICACHE_STATS_EN: when defined, the block adds outputs hit_count[15:0] and miss_count[15:0].
REQ-034 hit_count increments once per IDLE hit cycle with read=1.
REQ-035 miss_count increments once per IDLE->MEM_READ transition.
REQ-036 Both counters saturate at 16'hFFFF and clear on reset.
REQ-037 Without ICACHE_STATS_EN: the count ports and counter logic are absent; all other behaviour is identical.

Verification
REQ-038 Cold miss: reset, then read=1, address=10'h000 -> busywait=1; mem_read=1 with mem_address=6'h00; after memory completion and UPDATE, busywait=0 and instruction = bytes 3..0 of block 0.
REQ-039 Sequential hits: address 10'h004, 10'h008, 10'h00C after the fill -> busywait=0 each cycle, words 1, 2, 3 returned, no mem_read pulse.
REQ-040 Conflict: address 10'h080 (same index 0, tag 1) -> miss and mem_address=6'h08; then address 10'h000 -> miss again.
REQ-041 Reset mid-refill: assert reset during MEM_READ -> mem_read=0 at once; after release, address 10'h000 misses (valid cleared).
REQ-042 Address change during refill: switch from 10'h010 to 10'h020 in MEM_READ -> line 1 filled, then a second miss with mem_address=6'h02.
REQ-043 ICACHE_STATS_EN defined: 1 miss followed by 3 hits -> miss_count=1, hit_count=3.
